// File: rtl/timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] BCD_ZERO     = 8'h00;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // A value is loadable only if every nibble is a BCD digit and seconds stay below 60.
  function automatic logic bcd_valid(input logic [7:0] min, input logic [7:0] sec);
    return (min[7:4] <= DIGIT_MAX) && (min[3:0] <= DIGIT_MAX) &&
           (sec[7:4] <= SEC_TENS_MAX) && (sec[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One combinational BCD down-counting digit with borrow chaining.
module bcd_digit_down #(
  parameter int MAX_DIGIT = 9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next,
  output logic       borrow_out
);

  assign borrow_out = borrow_in && (digit == 4'd0);
  assign next       = !borrow_in        ? digit :
                      (digit == 4'd0)   ? 4'(MAX_DIGIT) :
                                          digit - 4'd1;

endmodule

// File: rtl/countdown_timer_bcd.sv
// Loadable mm:ss BCD countdown timer with done pulse.
// Optional buzzer output `alarm` is built when COUNTDOWN_ALARM_EN is defined.
module countdown_timer_bcd
  import timer_pkg::*;
`ifdef COUNTDOWN_ALARM_EN
#(
  parameter int ALARM_TICKS = 10
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr_flag,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] cnt_min,
  output logic [7:0] cnt_sec,
  output logic       running,
`ifdef COUNTDOWN_ALARM_EN
  output logic       alarm,
`endif
  output logic       done,
  output logic       load_err
);

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic       done_q, done_d;
  logic       load_err_q, load_err_d;
  logic       alarm_clr;

  // Borrow chain: seconds ones, seconds tens, minutes ones, minutes tens.
  logic [4:0]  borrow;
  logic [15:0] dec_val;

  assign borrow[0] = 1'b1;

  bcd_digit_down #(.MAX_DIGIT(9)) u_sec_ones (
    .digit(sec_q[3:0]), .borrow_in(borrow[0]), .next(dec_val[3:0]),   .borrow_out(borrow[1]));
  bcd_digit_down #(.MAX_DIGIT(5)) u_sec_tens (
    .digit(sec_q[7:4]), .borrow_in(borrow[1]), .next(dec_val[7:4]),   .borrow_out(borrow[2]));
  bcd_digit_down #(.MAX_DIGIT(9)) u_min_ones (
    .digit(min_q[3:0]), .borrow_in(borrow[2]), .next(dec_val[11:8]),  .borrow_out(borrow[3]));
  bcd_digit_down #(.MAX_DIGIT(9)) u_min_tens (
    .digit(min_q[7:4]), .borrow_in(borrow[3]), .next(dec_val[15:12]), .borrow_out(borrow[4]));

  // A borrow out of the top digit means the value is already 00:00.
  logic value_zero;
  assign value_zero = borrow[4];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    alarm_clr  = 1'b0;

    if (clr_flag) begin
      min_d     = BCD_ZERO;
      sec_d     = BCD_ZERO;
      state_d   = IDLE;
      alarm_clr = 1'b1;
    end else if (load) begin
      if (state_q != RUN) begin
        if (!bcd_valid(load_min, load_sec)) begin
          load_err_d = 1'b1;
        end else begin
          min_d     = load_min;
          sec_d     = load_sec;
          alarm_clr = 1'b1;
          if (state_q != PAUSE) state_d = IDLE;
        end
      end
    end else if (start) begin
      alarm_clr = 1'b1;
      if ((state_q == IDLE && !value_zero) || state_q == PAUSE) state_d = RUN;
    end else if (pause && state_q == RUN) begin
      state_d = PAUSE;
    end else if (en && state_q == RUN) begin
      // Holding at 00:00 instead of applying the wrapped value keeps the count from going below zero.
      if (value_zero) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        {min_d, sec_d} = dec_val;
        if (dec_val == {BCD_ZERO, BCD_ZERO}) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= IDLE;
      min_q      <= BCD_ZERO;
      sec_q      <= BCD_ZERO;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt_min  = min_q;
  assign cnt_sec  = sec_q;
  assign running  = (state_q == RUN);
  assign done     = done_q;
  assign load_err = load_err_q;

`ifdef COUNTDOWN_ALARM_EN
  localparam int TW = $clog2(ALARM_TICKS + 1);

  logic          alarm_q, alarm_d;
  logic [TW-1:0] tick_q, tick_d;

  // Ticks are counted from the first en after done; the done edge itself is not counted.
  always_comb begin
    alarm_d = alarm_q;
    tick_d  = tick_q;
    if (alarm_clr) begin
      alarm_d = 1'b0;
      tick_d  = '0;
    end else if (done_d) begin
      alarm_d = 1'b1;
      tick_d  = '0;
    end else if (alarm_q && en) begin
      if (tick_q == TW'(ALARM_TICKS - 1)) begin
        alarm_d = 1'b0;
        tick_d  = '0;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
      tick_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      tick_q  <= tick_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd; alarm checks build with COUNTDOWN_ALARM_EN.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       rst, en, clr_flag, load, start, pause;
  logic [7:0] load_min, load_sec;
  logic [7:0] cnt_min, cnt_sec;
  logic       running, done, load_err;
`ifdef COUNTDOWN_ALARM_EN
  logic       alarm;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

`ifdef COUNTDOWN_ALARM_EN
  countdown_timer_bcd #(.ALARM_TICKS(3)) dut (
`else
  countdown_timer_bcd dut (
`endif
    .clk(clk), .rst(rst), .en(en), .clr_flag(clr_flag), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .cnt_min(cnt_min), .cnt_sec(cnt_sec), .running(running),
`ifdef COUNTDOWN_ALARM_EN
    .alarm(alarm),
`endif
    .done(done), .load_err(load_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic do_en();
    en = 1'b1; cycle(); en = 1'b0;
  endtask

  task automatic do_clr();
    clr_flag = 1'b1; cycle(); clr_flag = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_flag = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = 8'h00; load_sec = 8'h00;
    #1;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_value",    {cnt_min, cnt_sec}, 16'h0000);
    check("reset_running",  16'(running), 16'd0);
    check("reset_done",     16'(done), 16'd0);
    check("reset_load_err", 16'(load_err), 16'd0);
`ifdef COUNTDOWN_ALARM_EN
    check("reset_alarm",    16'(alarm), 16'd0);
`endif

    // 01:00 -> 00:59 -> 00:58
    do_load(8'h01, 8'h00);
    check("load_0100",      {cnt_min, cnt_sec}, 16'h0100);
    check("idle_not_run",   16'(running), 16'd0);
    do_start();
    check("start_running",  16'(running), 16'd1);
    do_en();
    check("dec_0100",       {cnt_min, cnt_sec}, 16'h0059);
    do_en();
    check("dec_0059",       {cnt_min, cnt_sec}, 16'h0058);
    check("still_running",  16'(running), 16'd1);
    do_clr();
    check("clr_value",      {cnt_min, cnt_sec}, 16'h0000);
    check("clr_idle",       16'(running), 16'd0);

    // Terminal count from 00:02
    do_load(8'h00, 8'h02);
    do_start();
    do_en();
    check("dec_0002",       {cnt_min, cnt_sec}, 16'h0001);
    check("no_early_done",  16'(done), 16'd0);
    do_en();
    check("reach_zero",     {cnt_min, cnt_sec}, 16'h0000);
    check("done_pulse",     16'(done), 16'd1);
    check("done_not_run",   16'(running), 16'd0);
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_rise",     16'(alarm), 16'd1);
`endif
    cycle();
    check("done_one_cycle", 16'(done), 16'd0);
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_hold",     16'(alarm), 16'd1);
`endif
    do_en();
    check("no_wrap",        {cnt_min, cnt_sec}, 16'h0000);
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_tick1",    16'(alarm), 16'd1);
`endif
    do_en();
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_tick2",    16'(alarm), 16'd1);
`endif
    do_en();
    check("no_wrap2",       {cnt_min, cnt_sec}, 16'h0000);
`ifdef COUNTDOWN_ALARM_EN
    check("alarm_fall",     16'(alarm), 16'd0);
`endif
    do_start();
    check("start_in_done",  16'(running), 16'd0);

    // Minute borrows
    do_clr();
    do_load(8'h10, 8'h00);
    do_start();
    do_en();
    check("dec_1000",       {cnt_min, cnt_sec}, 16'h0959);
    do_clr();
    do_load(8'h99, 8'h59);
    do_start();
    do_en();
    check("dec_9959",       {cnt_min, cnt_sec}, 16'h9958);

    // Pause beats a simultaneous en; load while paused
    pause = 1'b1; en = 1'b1; cycle(); pause = 1'b0; en = 1'b0;
    check("pause_no_dec",   {cnt_min, cnt_sec}, 16'h9958);
    check("pause_state",    16'(running), 16'd0);
    do_load(8'h05, 8'h30);
    check("load_in_pause",  {cnt_min, cnt_sec}, 16'h0530);
    do_en();
    check("pause_holds",    {cnt_min, cnt_sec}, 16'h0530);
    do_start();
    check("resume",         16'(running), 16'd1);
    do_en();
    check("dec_0530",       {cnt_min, cnt_sec}, 16'h0529);

    // Load in RUN is ignored with no error
    do_load(8'h01, 8'h00);
    check("load_in_run",    {cnt_min, cnt_sec}, 16'h0529);
    check("load_run_noerr", 16'(load_err), 16'd0);
    check("load_run_state", 16'(running), 16'd1);

    // Invalid loads while paused
    pause = 1'b1; cycle(); pause = 1'b0;
    do_load(8'h01, 8'h60);
    check("err_sec60",      16'(load_err), 16'd1);
    check("err_sec60_val",  {cnt_min, cnt_sec}, 16'h0529);
    cycle();
    check("err_one_cycle",  16'(load_err), 16'd0);
    do_load(8'h1A, 8'h00);
    check("err_min1a",      16'(load_err), 16'd1);
    check("err_min1a_val",  {cnt_min, cnt_sec}, 16'h0529);
    do_start();
    check("err_kept_pause", 16'(running), 16'd1);

    // Start with 00:00 in IDLE is ignored
    do_clr();
    do_start();
    check("start_zero",     16'(running), 16'd0);
    check("start_zero_dn",  16'(done), 16'd0);

`ifdef COUNTDOWN_ALARM_EN
    // clr_flag mid-alarm
    do_load(8'h00, 8'h01);
    do_start();
    do_en();
    check("alarm2_rise",    16'(alarm), 16'd1);
    do_en();
    check("alarm2_hold",    16'(alarm), 16'd1);
    do_clr();
    check("alarm2_clr",     16'(alarm), 16'd0);
`endif

    // rst during RUN
    do_load(8'h05, 8'h00);
    do_start();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_run_value",  {cnt_min, cnt_sec}, 16'h0000);
    check("rst_run_state",  16'(running), 16'd0);
    check("rst_run_done",   16'(done), 16'd0);
    check("rst_run_err",    16'(load_err), 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
